// File: rtl/axi_sram_slave.sv
// AXI3 slave in front of a word-addressed 32-bit RAM. Serves one read or write
// transaction at a time with INCR/FIXED bursts and OKAY/SLVERR responses.
module axi_sram_slave #(
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned ID_W      = 1,
  parameter string       INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ID_W-1:0] s_axi_arid,
  input  logic [31:0]     s_axi_araddr,
  input  logic [7:0]      s_axi_arlen,
  input  logic [2:0]      s_axi_arsize,
  input  logic [1:0]      s_axi_arburst,
  input  logic [1:0]      s_axi_arlock,
  input  logic [3:0]      s_axi_arcache,
  input  logic [2:0]      s_axi_arprot,
  input  logic            s_axi_arvalid,
  output logic            s_axi_arready,
  output logic [ID_W-1:0] s_axi_rid,
  output logic [31:0]     s_axi_rdata,
  output logic [1:0]      s_axi_rresp,
  output logic            s_axi_rlast,
  output logic            s_axi_rvalid,
  input  logic            s_axi_rready,
  input  logic [ID_W-1:0] s_axi_awid,
  input  logic [31:0]     s_axi_awaddr,
  input  logic [7:0]      s_axi_awlen,
  input  logic [2:0]      s_axi_awsize,
  input  logic [1:0]      s_axi_awburst,
  input  logic [1:0]      s_axi_awlock,
  input  logic [3:0]      s_axi_awcache,
  input  logic [2:0]      s_axi_awprot,
  input  logic            s_axi_awvalid,
  output logic            s_axi_awready,
  input  logic [ID_W-1:0] s_axi_wid,
  input  logic [31:0]     s_axi_wdata,
  input  logic [3:0]      s_axi_wstrb,
  input  logic            s_axi_wlast,
  input  logic            s_axi_wvalid,
  output logic            s_axi_wready,
  output logic [ID_W-1:0] s_axi_bid,
  output logic [1:0]      s_axi_bresp,
  output logic            s_axi_bvalid,
  input  logic            s_axi_bready
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StRd, StWd, StWb} state_e;

  state_e          state_q;
  logic [ID_W-1:0] id_q;
  logic [31:0]     addr_q;
  logic [7:0]      cnt_q;
  logic [2:0]      size_q;
  logic [1:0]      burst_q;
  logic            err_q;
  logic            pri_rd_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem_q [DEPTH];

  logic            ar_hs, aw_hs, w_hs, last_beat, w_err;
  logic [31:0]     next_addr;
  logic [IdxW-1:0] ar_idx, next_idx, cur_idx;

  // FIXED and the reserved burst type keep the address; INCR and WRAP step it.
  always_comb begin
    next_addr = addr_q;
    if (burst_q == 2'b01 || burst_q == 2'b10) begin
      next_addr = addr_q + (32'd1 << size_q);
    end
  end

  assign ar_idx    = s_axi_araddr[IdxW+1:2];
  assign next_idx  = next_addr[IdxW+1:2];
  assign cur_idx   = addr_q[IdxW+1:2];
  assign last_beat = (cnt_q == 8'd0);
  assign w_err     = err_q | (s_axi_wlast != last_beat);

  assign s_axi_arready = (state_q == StIdle) & ~reset & s_axi_arvalid &
                         (~s_axi_awvalid | pri_rd_q);
  assign s_axi_awready = (state_q == StIdle) & ~reset & s_axi_awvalid &
                         (~s_axi_arvalid | ~pri_rd_q);
  assign s_axi_wready  = (state_q == StWd) & ~reset;

  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;

  assign s_axi_rvalid = (state_q == StRd);
  assign s_axi_rlast  = s_axi_rvalid & last_beat;
  assign s_axi_rresp  = (s_axi_rvalid & err_q) ? 2'b10 : 2'b00;
  assign s_axi_rid    = id_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_bvalid = (state_q == StWb);
  assign s_axi_bresp  = (s_axi_bvalid & err_q) ? 2'b10 : 2'b00;
  assign s_axi_bid    = id_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      id_q     <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      err_q    <= 1'b0;
      pri_rd_q <= 1'b1;
      rdata_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ar_hs) begin
            id_q     <= s_axi_arid;
            addr_q   <= s_axi_araddr;
            cnt_q    <= s_axi_arlen;
            size_q   <= s_axi_arsize;
            burst_q  <= s_axi_arburst;
            err_q    <= (s_axi_arsize > 3'd2) | (s_axi_arburst == 2'b11);
            pri_rd_q <= ~pri_rd_q;
            rdata_q  <= mem_q[ar_idx];
            state_q  <= StRd;
          end else if (aw_hs) begin
            id_q     <= s_axi_awid;
            addr_q   <= s_axi_awaddr;
            cnt_q    <= s_axi_awlen;
            size_q   <= s_axi_awsize;
            burst_q  <= s_axi_awburst;
            err_q    <= (s_axi_awsize > 3'd2) | (s_axi_awburst == 2'b11);
            pri_rd_q <= ~pri_rd_q;
            state_q  <= StWd;
          end
        end
        StRd: begin
          if (s_axi_rready) begin
            if (last_beat) begin
              state_q <= StIdle;
            end else begin
              cnt_q   <= cnt_q - 8'd1;
              addr_q  <= next_addr;
              rdata_q <= mem_q[next_idx];
            end
          end
        end
        StWd: begin
          if (w_hs) begin
            err_q <= w_err;
            if (last_beat) begin
              state_q <= StWb;
            end else begin
              cnt_q  <= cnt_q - 8'd1;
              addr_q <= next_addr;
            end
          end
        end
        StWb: begin
          if (s_axi_bready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // RAM has no reset; a beat carrying or following an error is dropped.
  always_ff @(posedge clk) begin
    if (w_hs && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi_wstrb[b]) mem_q[cur_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_awlock,
                       s_axi_awcache, s_axi_awprot, s_axi_wid};

endmodule
